puf_reader: RTL and testbench

PUF_READER -- requirements
Module: puf_reader

---
 rtl/puf_reader.sv | 142 ++++++++++++++
 tb/tb_puf_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_reader.sv
// puf_reader: sequences a PUF array (clear, excite, settle) and reads out
// every word in ascending address order over a valid/ready output port.
// Optional build macro PUF_READER_VOTE_EN: three excitation rounds per
// address with a bitwise 2-of-3 majority on the captured samples.
//
// Output handshake: data_valid rises with data_out/data_addr already stable,
// and all three hold unchanged until a cycle where data_valid and
// data_ready are both 1. That cycle transfers the word. data_valid never
// depends combinationally on data_ready.
module puf_reader #(
    parameter int ADDR_BITS     = 4,
    parameter int OUT_BITS      = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    output logic                 puf_start,
    output logic                 puf_rst,
    output logic [ADDR_BITS-1:0] puf_addr,
    input  logic [OUT_BITS-1:0]  puf_data,
    output logic [OUT_BITS-1:0]  data_out,
    output logic [ADDR_BITS-1:0] data_addr,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EXCITE,
        S_WAIT,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_IDX    = '1;
    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t               state;
    state_t               state_nx;
    logic [7:0]           cnt;
    logic [ADDR_BITS-1:0] idx;
    logic                 xfer;

`ifdef PUF_READER_VOTE_EN
    logic [1:0]          rnd;
    logic [OUT_BITS-1:0] s0;
    logic [OUT_BITS-1:0] s1;
`endif

    assign xfer = (state == S_PRESENT) && data_ready;

    // Next-state logic; cnt counts cycles spent in the current state.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (req) state_nx = S_CLEAR;
            S_CLEAR:   if (cnt == 8'd1) state_nx = S_EXCITE;
            S_EXCITE:  if (cnt == SETTLE_LAST) state_nx = S_WAIT;
            S_WAIT:    if (cnt == 8'd1) state_nx = S_CAPTURE;
`ifdef PUF_READER_VOTE_EN
            S_CAPTURE: state_nx = (rnd == 2'd2) ? S_PRESENT : S_CLEAR;
`else
            S_CAPTURE: state_nx = S_PRESENT;
`endif
            S_PRESENT: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        state_nx = S_DONE;
                    end else begin
`ifdef PUF_READER_VOTE_EN
                        state_nx = S_CLEAR;
`else
                        state_nx = S_WAIT;
`endif
                    end
                end
            end
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // State, phase counter, word index and captured data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            data_out <= '0;
`ifdef PUF_READER_VOTE_EN
            rnd      <= '0;
            s0       <= '0;
            s1       <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
            // Index only advances after a transfer below the last word, and
            // returns to 0 once the readout completes.
            if (xfer && (idx != LAST_IDX)) idx <= idx + 1'b1;
            else if (state == S_DONE) idx <= '0;
            if (state == S_CAPTURE) begin
`ifdef PUF_READER_VOTE_EN
                case (rnd)
                    2'd0: begin
                        s0  <= puf_data;
                        rnd <= 2'd1;
                    end
                    2'd1: begin
                        s1  <= puf_data;
                        rnd <= 2'd2;
                    end
                    default: begin
                        data_out <= (s0 & s1) | (s0 & puf_data) | (s1 & puf_data);
                        rnd      <= 2'd0;
                    end
                endcase
`else
                data_out <= puf_data;
`endif
            end
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        puf_rst    = (state == S_IDLE) || (state == S_CLEAR) || (state == S_DONE);
        puf_start  = (state == S_EXCITE) || (state == S_WAIT) ||
                     (state == S_CAPTURE) || (state == S_PRESENT);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        data_valid = (state == S_PRESENT);
        puf_addr   = idx;
        data_addr  = idx;
    end

endmodule

// File: tb/tb_puf_reader.sv
// Bench for puf_reader: behavioural PUF stub, posedge monitor and a
// word-level reference model with randomized data and ready stalls.
module tb_puf_reader;

  localparam int AB = 4;
  localparam int OB = 8;
  localparam int SC = 16;
  localparam int NW = 16;
`ifdef PUF_READER_VOTE_EN
  localparam int EXP_RISES = 3 * NW;
`else
  localparam int EXP_RISES = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic req;
  logic data_ready;
  logic puf_start, puf_rst, data_valid, busy, done;
  logic [AB-1:0] puf_addr, data_addr;
  logic [OB-1:0] puf_data, data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  puf_reader #(.ADDR_BITS(AB), .OUT_BITS(OB), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .req(req),
    .puf_start(puf_start), .puf_rst(puf_rst), .puf_addr(puf_addr),
    .puf_data(puf_data), .data_out(data_out), .data_addr(data_addr),
    .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done)
  );

  // ---------------- PUF stub ----------------
  logic use_tbl = 1'b0;
  logic [OB-1:0] tbl[NW];
  logic [OB-1:0] vtab[NW][3];
  int exc_n = 0;
  logic start_d = 1'b0;

  function automatic logic [OB-1:0] dflt_vote(input int a, input int r);
    if (a == 0) return (r == 2) ? 8'h0F : 8'hF0;
    return (r == 1) ? 8'h00 : (8'hA0 | OB'(a));
  endfunction

  function automatic logic [OB-1:0] stub(input int a, input int r);
`ifdef PUF_READER_VOTE_EN
    return use_tbl ? vtab[a][r] : dflt_vote(a, r);
`else
    return use_tbl ? tbl[a] : (8'hA0 | OB'(a));
`endif
  endfunction

  // Round = index of the excitation (puf_start rise) within the readout.
  always @(posedge clk) begin
    start_d <= puf_start;
    if (!busy) exc_n <= 0;
    else if (puf_start && !start_d) exc_n <= exc_n + 1;
    puf_data <= stub(int'(puf_addr), (exc_n == 0) ? 0 : (exc_n - 1) % 3);
  end

  // ---------------- reference model ----------------
  function automatic logic [OB-1:0] exp_word(input int a);
`ifdef PUF_READER_VOTE_EN
    logic [OB-1:0] s[3];
    logic [OB-1:0] r;
    for (int k = 0; k < 3; k++) s[k] = use_tbl ? vtab[a][k] : dflt_vote(a, k);
    for (int b = 0; b < OB; b++) begin
      int ones;
      ones = int'(s[0][b]) + int'(s[1][b]) + int'(s[2][b]);
      r[b] = (ones >= 2);
    end
    return r;
`else
    return use_tbl ? tbl[a] : (8'hA0 | OB'(a));
`endif
  endfunction

  logic [AB+OB-1:0] exp_q[$];
  logic [AB+OB-1:0] got_q[$];

  task automatic build_exp();
    exp_q.delete();
    for (int a = 0; a < NW; a++) exp_q.push_back({AB'(a), exp_word(a)});
  endtask

  // ---------------- monitor ----------------
  int done_n, start_rises, stable_err, max_stall, stall_run;
  int cyc = 0, rise_cyc, valid_gap, rst_run, rst_at_start;
  logic want_valid, prev_stall, mstart_d, mvalid_d;
  logic [AB+OB-1:0] prev_word;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0; stall_run = 0; rst_run = 0;
      mstart_d = 1'b0; mvalid_d = 1'b0; want_valid = 1'b0;
    end else begin
      if (data_valid && data_ready) got_q.push_back({data_addr, data_out});
      if (done) done_n++;
      if (prev_stall && {data_addr, data_out} !== prev_word) stable_err++;
      if (prev_stall && !data_valid) stable_err++;
      prev_stall = data_valid && !data_ready;
      prev_word = {data_addr, data_out};
      if (data_valid && !data_ready) stall_run++;
      else begin
        if (stall_run > max_stall) max_stall = stall_run;
        stall_run = 0;
      end
      if (puf_start && !mstart_d) begin
        start_rises++; rise_cyc = cyc; rst_at_start = rst_run; want_valid = 1'b1;
      end
      if (want_valid && data_valid && !mvalid_d) begin
        valid_gap = cyc - rise_cyc; want_valid = 1'b0;
      end
      rst_run = (busy && puf_rst) ? rst_run + 1 : 0;
      mstart_d = puf_start;
      mvalid_d = data_valid;
    end
  end

  task automatic clear_mon();
    got_q.delete();
    done_n = 0; start_rises = 0; stable_err = 0; max_stall = 0;
    valid_gap = -1; rst_at_start = -1;
  endtask

  // mode 0: ready high; 1: random ready; 2: 5-cycle stall at stall_addr;
  // 3: ready high with req pulsed randomly while busy.
  task automatic run_readout(input int mode, input int stall_addr);
    int stalled;
    stalled = 0;
    @(negedge clk); req = 1'b1; data_ready = 1'b1;
    @(negedge clk); req = 1'b0;
    for (int c = 0; c < 6000 && done_n == 0; c++) begin
      @(negedge clk);
      case (mode)
        1: data_ready = 1'($urandom_range(0, 1));
        2: begin
          if (data_valid && int'(data_addr) == stall_addr && stalled < 5) begin
            data_ready = 1'b0; stalled++;
          end else data_ready = 1'b1;
        end
        3: begin
          data_ready = 1'b1;
          req = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        default: data_ready = 1'b1;
      endcase
    end
    req = 1'b0; data_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_n == 0) begin
      failures++; $display("FAIL done_timeout mode=%0d got no done pulse", mode);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req = 1'b0; data_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({puf_rst, puf_start, puf_addr, data_out, data_addr, data_valid, busy, done}
        !== {1'b1, 1'b0, {AB{1'b0}}, {OB{1'b0}}, {AB{1'b0}}, 3'b000}) begin
      failures++;
      $display("FAIL reset_values rst=%b start=%b addr=%h out=%h daddr=%h v=%b busy=%b done=%b",
               puf_rst, puf_start, puf_addr, data_out, data_addr, data_valid, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    use_tbl = 1'b0; build_exp(); clear_mon();
    run_readout(0, 0);
    checks++;
    if (got_q.size() != NW) begin
      failures++; $display("FAIL basic_count got=%0d want=%0d", got_q.size(), NW);
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_word[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
    checks++;
    if (done_n != 1) begin failures++; $display("FAIL basic_done got=%0d want=1", done_n); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_fall got=%b want=0", busy); end
    checks++;
    if (valid_gap != SC + 3) begin
      failures++; $display("FAIL start_to_capture got=%0d want=%0d", valid_gap - 1, SC + 2);
    end
    checks++;
    if (rst_at_start != 2) begin
      failures++; $display("FAIL clear_len got=%0d want=2", rst_at_start);
    end
    checks++;
    if (start_rises != EXP_RISES) begin
      failures++; $display("FAIL excite_rounds got=%0d want=%0d", start_rises, EXP_RISES);
    end
  endtask

  task automatic test_stall();
    use_tbl = 1'b0; build_exp(); clear_mon();
    run_readout(2, 3);
    checks++;
    if (max_stall < 5) begin failures++; $display("FAIL stall_len got=%0d want>=5", max_stall); end
    checks++;
    if (stable_err != 0) begin failures++; $display("FAIL stall_stable got=%0d want=0", stable_err); end
    checks++;
    if (got_q.size() != NW) begin
      failures++; $display("FAIL stall_count got=%0d want=%0d", got_q.size(), NW);
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stall_word[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int pass = 0; pass < 2; pass++) begin
      use_tbl = 1'b1;
      for (int a = 0; a < NW; a++) begin
        tbl[a] = OB'($urandom);
        for (int k = 0; k < 3; k++) vtab[a][k] = OB'($urandom);
      end
      build_exp(); clear_mon();
      run_readout(1, 0);
      checks++;
      if (stable_err != 0) begin failures++; $display("FAIL rand_stable got=%0d want=0", stable_err); end
      checks++;
      if (done_n != 1) begin failures++; $display("FAIL rand_done got=%0d want=1", done_n); end
      checks++;
      if (got_q.size() != NW) begin
        failures++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), NW);
      end
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_word[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
        end
      end
    end
    use_tbl = 1'b0;
  endtask

  task automatic test_busy_req();
    use_tbl = 1'b0; build_exp(); clear_mon();
    run_readout(3, 0);
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() != NW) begin
      failures++; $display("FAIL busyreq_count got=%0d want=%0d", got_q.size(), NW);
    end
    checks++;
    if (done_n != 1) begin failures++; $display("FAIL busyreq_done got=%0d want=1", done_n); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busyreq_idle got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int c;
    // Reset while exciting.
    clear_mon();
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    for (c = 0; c < 50 && !puf_start; c++) @(negedge clk);
    checks++;
    if (!puf_start) begin failures++; $display("FAIL excite_reach got=0 want=1"); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({puf_rst, puf_start, puf_addr, data_out, data_addr, data_valid, busy, done}
        !== {1'b1, 1'b0, {AB{1'b0}}, {OB{1'b0}}, {AB{1'b0}}, 3'b000}) begin
      failures++;
      $display("FAIL reset_excite rst=%b start=%b addr=%h out=%h v=%b busy=%b",
               puf_rst, puf_start, puf_addr, data_out, data_valid, busy);
    end
    reset = 1'b0;
    // Reset while presenting word 7 (held off by ready low).
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    for (c = 0; c < 3000 && !(data_valid && data_addr == AB'(7)); c++) begin
      @(negedge clk);
      data_ready = (puf_addr != AB'(7));
    end
    checks++;
    if (!(data_valid && data_addr == AB'(7))) begin
      failures++; $display("FAIL present7_reach got=%h want=7", data_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({puf_rst, puf_start, puf_addr, data_out, data_addr, data_valid, busy, done}
        !== {1'b1, 1'b0, {AB{1'b0}}, {OB{1'b0}}, {AB{1'b0}}, 3'b000}) begin
      failures++;
      $display("FAIL reset_present rst=%b start=%b addr=%h out=%h v=%b busy=%b",
               puf_rst, puf_start, puf_addr, data_out, data_valid, busy);
    end
    reset = 1'b0; data_ready = 1'b1;
    // Fresh readout restarts at address 0.
    use_tbl = 1'b0; build_exp(); clear_mon();
    run_readout(0, 0);
    checks++;
    if (got_q.size() != NW) begin
      failures++; $display("FAIL restart_count got=%0d want=%0d", got_q.size(), NW);
    end
    for (int i = 0; i < NW; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL restart_word[%0d] got=%h want=%h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    clear_mon();
    @(negedge clk); req = 1'b1; data_ready = 1'b1;
    for (c = 0; c < 6000 && !done; c++) @(negedge clk);
    checks++;
    if (!done) begin failures++; $display("FAIL b2b_done got=0 want=1"); end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle done=%b busy=%b want 0 0", done, busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, puf_rst, puf_start} !== 3'b110) begin
      failures++; $display("FAIL b2b_restart busy=%b rst=%b start=%b want 1 1 0", busy, puf_rst, puf_start);
    end
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; data_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_busy_req();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
